tft_layer_compositor: RTL and testbench

//  Parametrised TFT timing generator and N-layer window compositor for the clk_vga domain.

---
 rtl/tft_layer_compositor.sv | 215 +++++++++++++++++++++
 tb/tb_tft_layer_compositor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_layer_compositor.sv
// TFT timing generator with N windowed layers: issues window-local read requests and
// merges the returned pixels by fixed priority with per-layer colour-key transparency.
module tft_layer_compositor #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 21,
    parameter int N_LAYERS = 4,
    parameter int CW       = 11,
    parameter int DW       = 16,
    parameter int RD_LAT   = 2,
    parameter logic [DW-1:0] BG_COLOR = '0,
    parameter logic [DW-1:0] KEY      = DW'(16'hF81F)
) (
    input  logic                     clk_vga,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_LAYERS-1:0]      layer_en,
    input  logic [N_LAYERS-1:0]      layer_key_en,
    input  logic [N_LAYERS*CW-1:0]   layer_x,
    input  logic [N_LAYERS*CW-1:0]   layer_y,
    input  logic [N_LAYERS*CW-1:0]   layer_w,
    input  logic [N_LAYERS*CW-1:0]   layer_h,
    output logic [N_LAYERS-1:0]      layer_req,
    output logic [N_LAYERS*CW-1:0]   layer_hcount,
    output logic [N_LAYERS*CW-1:0]   layer_vcount,
    input  logic [N_LAYERS*DW-1:0]   layer_data,
    output logic [DW-1:0]            tft_rgb,
    output logic                     tft_hs,
    output logic                     tft_vs,
    output logic                     tft_de,
    output logic                     frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;
    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

    logic [CW-1:0] h_cnt, v_cnt;
    logic          at_origin;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic [N_LAYERS-1:0]    sh_en, sh_key;
    logic [N_LAYERS*CW-1:0] sh_x, sh_y, sh_w, sh_h;

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            sh_en  <= '0;
            sh_key <= '0;
            sh_x   <= '0;
            sh_y   <= '0;
            sh_w   <= '0;
            sh_h   <= '0;
        end else if (at_origin) begin
            sh_en  <= layer_en;
            sh_key <= layer_key_en;
            sh_x   <= layer_x;
            sh_y   <= layer_y;
            sh_w   <= layer_w;
            sh_h   <= layer_h;
        end
    end

    // Pixel (0,0) uses the live geometry being sampled, so a new frame never sees stale windows.
    logic [N_LAYERS-1:0]    eff_en, eff_key;
    logic [N_LAYERS*CW-1:0] eff_x, eff_y, eff_w, eff_h;
    assign eff_en  = at_origin ? layer_en     : sh_en;
    assign eff_key = at_origin ? layer_key_en : sh_key;
    assign eff_x   = at_origin ? layer_x      : sh_x;
    assign eff_y   = at_origin ? layer_y      : sh_y;
    assign eff_w   = at_origin ? layer_w      : sh_w;
    assign eff_h   = at_origin ? layer_h      : sh_h;

    logic active;
    assign active = (h_cnt < HA) && (v_cnt < VA);

    logic [N_LAYERS-1:0]    hit;
    logic [N_LAYERS*CW-1:0] loc_h, loc_v;

    for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
        logic [CW-1:0] w, hgt;
        logic [CW:0]   x0, x1, y0, y1;
        assign w   = eff_w[i*CW +: CW];
        assign hgt = eff_h[i*CW +: CW];
        assign x0  = {1'b0, eff_x[i*CW +: CW]};
        assign y0  = {1'b0, eff_y[i*CW +: CW]};
        assign x1  = x0 + {1'b0, w};
        assign y1  = y0 + {1'b0, hgt};
        assign hit[i] = active && eff_en[i] && (w != '0) && (hgt != '0)
                     && ({1'b0, h_cnt} >= x0) && ({1'b0, h_cnt} < x1)
                     && ({1'b0, v_cnt} >= y0) && ({1'b0, v_cnt} < y1);
        assign loc_h[i*CW +: CW] = hit[i] ? h_cnt - eff_x[i*CW +: CW] : '0;
        assign loc_v[i*CW +: CW] = hit[i] ? v_cnt - eff_y[i*CW +: CW] : '0;
    end

    sync_t sync_d;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d    = SYNC_IDLE;
        sync_d.hs = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        sync_d.vs = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        sync_d.de = active;
        sync_d.fs = at_origin;
    end

    logic [N_LAYERS-1:0] key_s1;
    sync_t               sync_s1;

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            layer_req    <= '0;
            layer_hcount <= '0;
            layer_vcount <= '0;
            key_s1       <= '0;
            sync_s1      <= SYNC_IDLE;
        end else begin
            layer_req    <= enable ? hit            : '0;
            layer_hcount <= enable ? loc_h          : '0;
            layer_vcount <= enable ? loc_v          : '0;
            key_s1       <= enable ? (hit & eff_key) : '0;
            sync_s1      <= enable ? sync_d         : SYNC_IDLE;
        end
    end

    // Request, key and timing travel together for the RD_LAT clocks the sources take.
    logic [N_LAYERS-1:0] req_dl  [RD_LAT];
    logic [N_LAYERS-1:0] key_dl  [RD_LAT];
    sync_t               sync_dl [RD_LAT];

    // NOTE: the delay line is reset, not left as uninitialised storage, because a stale
    // entry would reach the pins right after reset.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < RD_LAT; j++) begin
                req_dl[j]  <= '0;
                key_dl[j]  <= '0;
                sync_dl[j] <= SYNC_IDLE;
            end
        end else begin
            req_dl[0]  <= layer_req;
            key_dl[0]  <= key_s1;
            sync_dl[0] <= sync_s1;
            for (int j = 1; j < RD_LAT; j++) begin
                req_dl[j]  <= req_dl[j-1];
                key_dl[j]  <= key_dl[j-1];
                sync_dl[j] <= sync_dl[j-1];
            end
        end
    end

    // Scan from lowest priority upward; the last opaque layer written wins.
    logic [DW-1:0] pix_d;
    always_comb begin
        pix_d = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (req_dl[RD_LAT-1][i] &&
                !(key_dl[RD_LAT-1][i] && (layer_data[i*DW +: DW] == KEY)))
                pix_d = layer_data[i*DW +: DW];
        end
        if (!sync_dl[RD_LAT-1].de)
            pix_d = '0;
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            tft_rgb     <= '0;
            tft_hs      <= 1'b1;
            tft_vs      <= 1'b1;
            tft_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            tft_rgb     <= pix_d;
            tft_hs      <= sync_dl[RD_LAT-1].hs;
            tft_vs      <= sync_dl[RD_LAT-1].vs;
            tft_de      <= sync_dl[RD_LAT-1].de;
            frame_start <= sync_dl[RD_LAT-1].fs;
        end
    end

endmodule

// File: tb/tb_tft_layer_compositor.sv
// Randomised bench for tft_layer_compositor: a frame-level reference model fills
// scoreboard queues that a separate monitor drains against the pins every clock.
module tb_tft_layer_compositor;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 10, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int N = 4, CW = 8, DW = 16, RD_LAT = 2, PER = 10;
    localparam logic [DW-1:0] BG  = 16'h0841;
    localparam logic [DW-1:0] KEY = 16'hF81F;
    localparam logic [127:0] PIX_IDLE = 128'({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [N-1:0]    layer_en = '0, layer_key_en = '0, layer_req;
    logic [N*CW-1:0] layer_x = '0, layer_y = '0, layer_w = '0, layer_h = '0;
    logic [N*CW-1:0] layer_hcount, layer_vcount;
    logic [N*DW-1:0] layer_data;
    logic [DW-1:0]   tft_rgb;
    logic            tft_hs, tft_vs, tft_de, frame_start;

    tft_layer_compositor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .N_LAYERS(N), .CW(CW), .DW(DW), .RD_LAT(RD_LAT),
        .BG_COLOR(BG), .KEY(KEY)
    ) dut (
        .clk_vga(clk), .rst(rst), .enable(enable),
        .layer_en(layer_en), .layer_key_en(layer_key_en),
        .layer_x(layer_x), .layer_y(layer_y), .layer_w(layer_w), .layer_h(layer_h),
        .layer_req(layer_req), .layer_hcount(layer_hcount), .layer_vcount(layer_vcount),
        .layer_data(layer_data),
        .tft_rgb(tft_rgb), .tft_hs(tft_hs), .tft_vs(tft_vs), .tft_de(tft_de),
        .frame_start(frame_start)
    );

    always #(PER/2) clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int salt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Image content of every layer source, addressed by window-local coordinates.
    function automatic logic [DW-1:0] src_fn(int i, int lx, int ly);
        if ((lx + 2*ly + 3*i + salt) % 4 == 0) return KEY;
        return DW'((i + 1) * 4099 + lx * 97 + ly * 31 + salt);
    endfunction

    // Layer sources: fixed RD_LAT latency, garbage on lanes without a request.
    logic [N*DW-1:0] src_pipe [RD_LAT];
    logic [N*DW-1:0] src_d;
    assign layer_data = src_pipe[RD_LAT-1];
    initial begin
        for (int j = 0; j < RD_LAT; j++) src_pipe[j] = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                src_d[i*DW +: DW] = layer_req[i]
                    ? src_fn(i, int'(layer_hcount[i*CW +: CW]), int'(layer_vcount[i*CW +: CW]))
                    : DW'($urandom);
            src_pipe[0] <= src_d;
            for (int j = 1; j < RD_LAT; j++) src_pipe[j] <= src_pipe[j-1];
        end
    end

    // Reference model: raster position, per-frame geometry and the expected pixel.
    typedef struct {
        longint         due;
        logic [127:0]   v;
    } ent_t;
    ent_t req_q[$], pix_q[$];
    int mh = 0, mv = 0;
    int g_x[N], g_y[N], g_w[N], g_h[N];
    bit g_en[N], g_key[N];
    logic [127:0] m_rv, m_pv;

    function automatic void model_pixel(int h, int v, output logic [127:0] rv,
                                        output logic [127:0] pv);
        logic [N-1:0]    req = '0;
        logic [N*CW-1:0] hc = '0, vc = '0;
        logic [DW-1:0]   rgb, d;
        bit act, done = 0;
        act = (h < HA) && (v < VA);
        rgb = act ? BG : '0;
        for (int i = 0; i < N; i++) begin
            if (act && g_en[i] && g_w[i] != 0 && g_h[i] != 0 &&
                h >= g_x[i] && h < g_x[i] + g_w[i] && v >= g_y[i] && v < g_y[i] + g_h[i]) begin
                req[i] = 1'b1;
                hc[i*CW +: CW] = CW'(h - g_x[i]);
                vc[i*CW +: CW] = CW'(v - g_y[i]);
                d = src_fn(i, h - g_x[i], v - g_y[i]);
                if (!done && !(g_key[i] && d == KEY)) begin
                    rgb = d;
                    done = 1;
                end
            end
        end
        rv = 128'({req, hc, vc});
        pv = 128'({rgb, !(h >= HA + HFP && h < HA + HFP + HSY),
                        !(v >= VA + VFP && v < VA + VFP + VSY), act, (h == 0 && v == 0)});
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                req_q.delete();
                pix_q.delete();
                mh = 0;
                mv = 0;
            end else begin
                m_rv = '0;
                m_pv = PIX_IDLE;
                if (enable) begin
                    if (mh == 0 && mv == 0) begin
                        for (int i = 0; i < N; i++) begin
                            g_x[i]   = int'(layer_x[i*CW +: CW]);
                            g_y[i]   = int'(layer_y[i*CW +: CW]);
                            g_w[i]   = int'(layer_w[i*CW +: CW]);
                            g_h[i]   = int'(layer_h[i*CW +: CW]);
                            g_en[i]  = layer_en[i];
                            g_key[i] = layer_key_en[i];
                        end
                    end
                    model_pixel(mh, mv, m_rv, m_pv);
                    mh++;
                    if (mh == HT) begin
                        mh = 0;
                        mv = (mv == VT - 1) ? 0 : mv + 1;
                    end
                end else begin
                    mh = 0;
                    mv = 0;
                end
                req_q.push_back('{longint'($time) + PER/2, m_rv});
                pix_q.push_back('{longint'($time) + (RD_LAT + 1) * PER + PER/2, m_pv});
            end
        end
    end

    // Monitor: compares every clock; with nothing due the pins must sit at reset values.
    logic [127:0] e_req, e_pix;
    ent_t         ent;
    longint       last_fs = -1;
    bit           fs_disturbed = 0;
    initial begin
        forever begin
            @(negedge clk);
            e_req = '0;
            e_pix = PIX_IDLE;
            if (req_q.size() > 0 && req_q[0].due == longint'($time)) begin
                ent = req_q.pop_front();
                e_req = ent.v;
            end
            if (pix_q.size() > 0 && pix_q[0].due == longint'($time)) begin
                ent = pix_q.pop_front();
                e_pix = ent.v;
            end
            check("req_counts", 128'({layer_req, layer_hcount, layer_vcount}), e_req);
            check("rgb_sync_fs", 128'({tft_rgb, tft_hs, tft_vs, tft_de, frame_start}), e_pix);
            if (frame_start) begin
                if (last_fs >= 0 && !fs_disturbed)
                    check("frame_period", 128'((longint'($time) - last_fs) / PER), 128'(HT * VT));
                last_fs = longint'($time);
                fs_disturbed = 0;
            end
        end
    end

    task automatic set_layer(int i, bit en, bit key, int x, int y, int w, int h);
        layer_en[i]          = en;
        layer_key_en[i]      = key;
        layer_x[i*CW +: CW]  = CW'(x);
        layer_y[i*CW +: CW]  = CW'(y);
        layer_w[i*CW +: CW]  = CW'(w);
        layer_h[i*CW +: CW]  = CW'(h);
    endtask

    task automatic clear_layers();
        for (int i = 0; i < N; i++) set_layer(i, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_line(int line);
        int n = 0;
        while (!(mv == line && mh == 0) && n < 2 * HT * VT) begin
            @(negedge clk);
            n++;
        end
        check("wait_line_timeout", 128'(n >= 2 * HT * VT), 128'(0));
    endtask

    initial begin
        salt = $urandom_range(0, 999);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(5);

        // Single layer window.
        clear_layers();
        set_layer(0, 1, 0, 10, 5, 4, 2);
        enable = 1'b1;
        run(HT * VT + 20);

        // Overlap with keying: keyed L0 falls through to L1, both keyed give background.
        set_layer(0, 1, 1, 4, 3, 6, 5);
        set_layer(1, 1, 1, 2, 2, 8, 6);
        run(HT * VT);
        set_layer(2, 1, 0, 0, 0, HA, VA);
        run(HT * VT);

        // Clipping at the right and bottom edges, empty and disabled layers.
        clear_layers();
        set_layer(0, 1, 0, HA - 2, 1, 10, 3);
        set_layer(1, 1, 0, 3, 3, 0, 4);
        set_layer(2, 0, 0, 3, 3, 5, 4);
        set_layer(3, 1, 0, 5, VA - 1, 3, 5);
        run(HT * VT);

        // Mid-frame geometry change takes effect only at the next frame.
        wait_line(2);
        layer_x[0 +: CW] = CW'(1);
        layer_x[CW +: CW] = CW'(7);
        layer_w[CW +: CW] = CW'(4);
        run(2 * HT * VT);

        // Asynchronous reset mid-frame, then a long disable.
        wait_line(5);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fs_disturbed = 1;
        run(HT * VT + 30);
        wait_line(4);
        enable = 1'b0;
        run(50);
        enable = 1'b1;
        fs_disturbed = 1;
        run(2 * HT * VT);

        // Random geometry changed at random points of the frame.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++)
                set_layer(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, HA + 3), $urandom_range(0, VA + 2),
                          ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9),
                          $urandom_range(0, 7));
            run($urandom_range(50, 500));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                run($urandom_range(5, 30));
                enable = 1'b1;
                fs_disturbed = 1;
            end
        end
        run(HT * VT + RD_LAT + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
